// File: rtl/div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional DIV_DONE_PULSE_EN adds a one-cycle done_o pulse on every completion.
module div #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [2*W-1:0] a_bi,
    input  logic [W-1:0]   b_bi,
    input  logic           start_i,
    output logic           busy_o,
    output logic [2*W-1:0] y_bo,
    output logic [W-1:0]   r_bo,
    output logic           div0_o
`ifdef DIV_DONE_PULSE_EN
    ,
    output logic           done_o
`endif
);

    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0] LAST = CW'(2*W-1);

    typedef enum logic [1:0] {IDLE, WORK, ZERO} state_t;

    state_t          state_q, state_d;
    // Only W bits are stored: the W+1-bit partial remainder exists between shift
    // and compare, and after a conditional subtract it is always < divisor.
    logic [W-1:0]    rem_q, rem_d;
    logic [2*W-1:0]  q_q, q_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  y_q, y_d;
    logic [W-1:0]    r_q, r_d;
    logic            div0_q, div0_d;
    logic            done_d;

    logic [W:0]      rem_sh;
    logic [W-1:0]    diff;
    logic            ge;

    assign rem_sh = {rem_q, q_q[2*W-1]};
    assign ge     = rem_sh >= {1'b0, dvs_q};
    // True difference is < divisor, so W-bit modular subtraction is exact.
    assign diff   = rem_sh[W-1:0] - dvs_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        r_d     = r_q;
        div0_d  = div0_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dvs_d   = b_bi;
                    q_d     = a_bi;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (b_bi == '0) ? ZERO : WORK;
                end
            end
            WORK: begin
                rem_d = ge ? diff : rem_sh[W-1:0];
                q_d   = {q_q[2*W-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    y_d     = q_d;
                    r_d     = rem_d;
                    div0_d  = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ZERO: begin
                y_d     = '1;
                r_d     = q_q[W-1:0];
                div0_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign y_bo   = y_q;
    assign r_bo   = r_q;
    assign div0_o = div0_q;

`ifdef DIV_DONE_PULSE_EN
    logic done_q;
    always_ff @(posedge clk_i) begin
        if (!rst_i) done_q <= 1'b0;
        else        done_q <= done_d;
    end
    assign done_o = done_q;
`else
    logic unused_done;
    assign unused_done = done_d;
`endif

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div (W=8): vector table, multi-cycle corner sequences,
// and a randomized sweep against an arithmetic reference model.
module tb_div;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [2*W-1:0] a_bi;
    logic [W-1:0]   b_bi;
    logic           start_i;
    logic           busy_o;
    logic [2*W-1:0] y_bo;
    logic [W-1:0]   r_bo;
    logic           div0_o;
`ifdef DIV_DONE_PULSE_EN
    logic           done_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_comp = 0;

    div #(.W(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .a_bi   (a_bi),
        .b_bi   (b_bi),
        .start_i(start_i),
        .busy_o (busy_o),
        .y_bo   (y_bo),
        .r_bo   (r_bo),
        .div0_o (div0_o)
`ifdef DIV_DONE_PULSE_EN
        ,
        .done_o (done_o)
`endif
    );

    always #5 clk = ~clk;

`ifdef DIV_DONE_PULSE_EN
    always @(negedge clk) if (done_o) n_done++;
`endif

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [2*W-1:0] y;
        logic [W-1:0]   r;
        logic           d0;
        int             cyc;
    } vec_t;

    vec_t vec[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: pulses start for one edge, then counts busy cycles.
    // Returns at the negedge where busy_o is first low again.
    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, output int cyc);
        a_bi = a; b_bi = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_bi = $urandom; b_bi = $urandom;
        cyc = 0;
        while (busy_o && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        n_comp++;
`ifdef DIV_DONE_PULSE_EN
        chk("done_pulse", {31'd0, done_o}, 32'd1);
`endif
    endtask

    task automatic check_result(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b, input int cyc);
        logic [2*W-1:0] ey;
        logic [W-1:0]   er;
        logic [2*W-1:0] ew;
        if (b == '0) begin
            ey = '1;
            er = a[W-1:0];
        end else begin
            ey = a / {8'd0, b};
            ew = a % {8'd0, b};
            er = ew[W-1:0];
        end
        chk({tag, "_y"},    {16'd0, y_bo}, {16'd0, ey});
        chk({tag, "_r"},    {24'd0, r_bo}, {24'd0, er});
        chk({tag, "_div0"}, {31'd0, div0_o}, {31'd0, (b == '0)});
        chk({tag, "_cyc"},  cyc, (b == '0) ? 1 : 2*W);
    endtask

    initial begin
        int cyc;
        logic [2*W-1:0] ra;
        logic [W-1:0]   rb;

        vec[0] = '{16'd1000,  8'd7,    16'd142,   8'd6,    1'b0, 16};
        vec[1] = '{16'hFFFF,  8'hFF,   16'h0101,  8'd0,    1'b0, 16};
        vec[2] = '{16'd5,     8'd10,   16'd0,     8'd5,    1'b0, 16};
        vec[3] = '{16'h1234,  8'd0,    16'hFFFF,  8'h34,   1'b1, 1};
        vec[4] = '{16'd200,   8'd3,    16'd66,    8'd2,    1'b0, 16};
        vec[5] = '{16'hFFFF,  8'd1,    16'hFFFF,  8'd0,    1'b0, 16};
        vec[6] = '{16'd0,     8'd5,    16'd0,     8'd0,    1'b0, 16};
        vec[7] = '{16'h7FFF,  8'h80,   16'h00FF,  8'h7F,   1'b0, 16};

        rst_i = 1'b0; start_i = 1'b0; a_bi = '0; b_bi = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_y",    {16'd0, y_bo}, 32'd0);
        chk("rst_r",    {24'd0, r_bo}, 32'd0);
        chk("rst_div0", {31'd0, div0_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back (next start in first idle cycle).
        for (int i = 0; i < 8; i++) begin
            run_op(vec[i].a, vec[i].b, cyc);
            chk($sformatf("vec%0d_y", i),    {16'd0, y_bo},   {16'd0, vec[i].y});
            chk($sformatf("vec%0d_r", i),    {24'd0, r_bo},   {24'd0, vec[i].r});
            chk($sformatf("vec%0d_div0", i), {31'd0, div0_o}, {31'd0, vec[i].d0});
            chk($sformatf("vec%0d_cyc", i),  cyc, vec[i].cyc);
        end

        // Start and operand changes during WORK are ignored; outputs hold until completion.
        a_bi = 16'd1000; b_bi = 8'd7; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        a_bi = 16'd9; b_bi = 8'd3; start_i = 1'b1;
        chk("hold_y_midop", {16'd0, y_bo}, {16'd0, vec[7].y});
        @(negedge clk); cyc++;
        start_i = 1'b0;
        while (busy_o && cyc < 100) begin @(negedge clk); cyc++; end
        cyc--;
        n_comp++;
        chk("ign_y",   {16'd0, y_bo}, 32'd142);
        chk("ign_r",   {24'd0, r_bo}, 32'd6);
        chk("ign_cyc", cyc, 16);
        @(negedge clk);
        chk("ign_no_restart", {31'd0, busy_o}, 32'd0);

        // Reset during WORK aborts with no partial result and no done pulse.
        a_bi = 16'd1000; b_bi = 8'd7; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_y",    {16'd0, y_bo}, 32'd0);
        chk("abort_r",    {24'd0, r_bo}, 32'd0);
        run_op(16'd100, 8'd9, cyc);
        chk("post_abort_y", {16'd0, y_bo}, 32'd11);
        chk("post_abort_r", {24'd0, r_bo}, 32'd1);
        chk("post_abort_cyc", cyc, 16);

        // Randomized sweep with forced b=1, a=0 and b=0 corners.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            case (i % 10)
                0: rb = 8'd1;
                1: ra = '0;
                2: rb = 8'($urandom_range(1, 3));
                3: if (i % 50 == 3) rb = '0;
                default: ;
            endcase
            run_op(ra, rb, cyc);
            check_result($sformatf("rnd%0d", i), ra, rb, cyc);
        end

`ifdef DIV_DONE_PULSE_EN
        @(negedge clk);
        chk("done_count", n_done, n_comp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_chk);
        $fatal(1);
    end
endmodule
